// File: rtl/run_seq_pkg.sv
// Shared types and defaults for the run sequencer slice.
package run_seq_pkg;

    localparam int unsigned PC_W_DEF   = 10;
    localparam int unsigned CNT_W_DEF  = 16;
    // INIT phase length is limited to 1..15 cycles, so 4 bits always suffice.
    localparam int unsigned INIT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } run_state_t;

endpackage

// File: rtl/run_sequencer_if.sv
// Request/core-control bundle between top_level, the core and the run sequencer.
// master: requester/core side, slave: the sequencer itself.
interface run_sequencer_if
    import run_seq_pkg::*;
#(
    parameter int unsigned PC_W  = PC_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
);

    logic             req;
    logic             abort;
    logic [PC_W-1:0]  start_pc;
    logic             halt;
    logic             pc_load;
    logic [PC_W-1:0]  pc_init;
    logic             run_en;
    logic             done;
    logic             timeout;
    logic [CNT_W-1:0] cycle_cnt;

    modport master (
        output req, abort, start_pc, halt,
        input  pc_load, pc_init, run_en, done, timeout, cycle_cnt
    );

    modport slave (
        input  req, abort, start_pc, halt,
        output pc_load, pc_init, run_en, done, timeout, cycle_cnt
    );

endinterface

// File: rtl/run_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over enable).
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt_q
);

    logic [W-1:0] cnt_d;

    // Next count: clear, or increment until all-ones and then hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/run_sequencer.sv
// run_sequencer: turns a top-level req into INIT (PC preload) -> RUN -> DONE,
// drives core pc_load/run_en and measures run length in cycle_cnt.
// Optional watchdog: define RUN_WATCHDOG_EN to end a RUN after MAX_CYCLES
// cycles with timeout=1; otherwise timeout stays 0.
module run_sequencer
    import run_seq_pkg::*;
#(
    parameter int unsigned PC_W        = PC_W_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF,
`ifdef RUN_WATCHDOG_EN
    parameter int unsigned MAX_CYCLES  = 50000,
`endif
    parameter int unsigned INIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    run_sequencer_if.slave  bus
);

    run_state_t            state_q, state_d;
    logic [PC_W-1:0]       pc_init_q, pc_init_d;
    logic                  pc_load_q, pc_load_d;
    logic                  run_en_q, run_en_d;
    logic                  done_q, done_d;
    logic                  timeout_q, timeout_d;

    logic                  cnt_clr, cnt_en;
    logic [CNT_W-1:0]      cycle_cnt;
    logic                  init_clr, init_en;
    logic [INIT_CNT_W-1:0] init_cnt;

    // Run-length counter: counts every RUN cycle, saturating.
    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .cnt_q (cycle_cnt)
    );

    // INIT phase length counter.
    sat_counter #(.W(INIT_CNT_W)) u_init_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (init_clr),
        .en    (init_en),
        .cnt_q (init_cnt)
    );

    // Next-state, captured start address, counter controls and Moore outputs.
    always_comb begin
        state_d   = state_q;
        pc_init_d = pc_init_q;
        timeout_d = timeout_q;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        init_clr  = 1'b0;
        init_en   = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                // A new run restarts from INIT; done drops on this same edge.
                if (bus.req) begin
                    pc_init_d = bus.start_pc;
                    timeout_d = 1'b0;
                    cnt_clr   = 1'b1;
                    init_clr  = 1'b1;
                    state_d   = INIT;
                end
            end
            INIT: begin
                if (bus.abort) begin
                    timeout_d = 1'b0;
                    state_d   = IDLE;
                end else if (init_cnt == INIT_CNT_W'(INIT_CYCLES - 1)) begin
                    state_d = RUN;
                end else begin
                    init_en = 1'b1;
                end
            end
            RUN: begin
                // Every RUN cycle is counted, including the one that leaves RUN.
                cnt_en = 1'b1;
                if (bus.abort) begin
                    timeout_d = 1'b0;
                    state_d   = IDLE;
                end else if (bus.halt) begin
                    timeout_d = 1'b0;
                    state_d   = DONE;
`ifdef RUN_WATCHDOG_EN
                end else if (cycle_cnt >= CNT_W'(MAX_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        pc_load_d = (state_d == INIT);
        run_en_d  = (state_d == RUN);
        done_d    = (state_d == DONE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pc_init_q <= '0;
            pc_load_q <= 1'b0;
            run_en_q  <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_init_q <= pc_init_d;
            pc_load_q <= pc_load_d;
            run_en_q  <= run_en_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.pc_load   = pc_load_q;
    assign bus.pc_init   = pc_init_q;
    assign bus.run_en    = run_en_q;
    assign bus.done      = done_q;
    assign bus.timeout   = timeout_q;
    assign bus.cycle_cnt = cycle_cnt;

endmodule

// File: tb/tb_run_sequencer.sv
// Directed self-checking bench for run_sequencer (main 16-bit instance,
// a 4-bit counter instance for saturation, and a watchdog instance when enabled).
module tb_run_sequencer;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    run_sequencer_if #(.PC_W(10), .CNT_W(16)) m_if ();
    run_sequencer_if #(.PC_W(10), .CNT_W(4))  s_if ();

    run_sequencer #(.PC_W(10), .CNT_W(16), .INIT_CYCLES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (m_if)
    );

    run_sequencer #(.PC_W(10), .CNT_W(4), .INIT_CYCLES(2)) dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (s_if)
    );

`ifdef RUN_WATCHDOG_EN
    run_sequencer_if #(.PC_W(10), .CNT_W(16)) w_if ();

    run_sequencer #(.PC_W(10), .CNT_W(16), .MAX_CYCLES(8), .INIT_CYCLES(2)) dut_wd (
        .clk   (clk),
        .reset (reset),
        .bus   (w_if)
    );
`endif

    // Posedges at 10, 20, 30 ...; negedges at 5, 15, 25 ...
    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        m_if.req = 1'b0; m_if.abort = 1'b0; m_if.halt = 1'b0; m_if.start_pc = '0;
        s_if.req = 1'b0; s_if.abort = 1'b0; s_if.halt = 1'b0; s_if.start_pc = '0;
`ifdef RUN_WATCHDOG_EN
        w_if.req = 1'b0; w_if.abort = 1'b0; w_if.halt = 1'b0; w_if.start_pc = '0;
`endif

        // Reset state
        #2;
        chk("rst_pc_load",   32'(m_if.pc_load),   32'd0);
        chk("rst_pc_init",   32'(m_if.pc_init),   32'd0);
        chk("rst_run_en",    32'(m_if.run_en),    32'd0);
        chk("rst_done",      32'(m_if.done),      32'd0);
        chk("rst_timeout",   32'(m_if.timeout),   32'd0);
        chk("rst_cycle_cnt", 32'(m_if.cycle_cnt), 32'd0);

        // Release reset at t=15 and pulse req with start_pc=0x020
        #13;
        reset = 1'b0;
        m_if.req = 1'b1;
        m_if.start_pc = 10'h020;
        tick();
        m_if.req = 1'b0;
        chk("r1_init0_pc_load", 32'(m_if.pc_load), 32'd1);
        chk("r1_init0_pc_init", 32'(m_if.pc_init), 32'h020);
        chk("r1_init0_run_en",  32'(m_if.run_en),  32'd0);
        tick();
        chk("r1_init1_pc_load", 32'(m_if.pc_load), 32'd1);
        chk("r1_init1_run_en",  32'(m_if.run_en),  32'd0);
        tick();
        chk("r1_run_pc_load",   32'(m_if.pc_load),   32'd0);
        chk("r1_run_run_en",    32'(m_if.run_en),    32'd1);
        chk("r1_run_cnt0",      32'(m_if.cycle_cnt), 32'd0);
        tick_n(4);
        chk("r1_run_cnt4",      32'(m_if.cycle_cnt), 32'd4);
        m_if.halt = 1'b1;
        tick();
        m_if.halt = 1'b0;
        chk("r1_done",          32'(m_if.done),      32'd1);
        chk("r1_done_run_en",   32'(m_if.run_en),    32'd0);
        chk("r1_done_cnt",      32'(m_if.cycle_cnt), 32'd5);
        chk("r1_done_timeout",  32'(m_if.timeout),   32'd0);

        // DONE holds while req stays low
        tick_n(3);
        chk("r1_hold_done",     32'(m_if.done),      32'd1);
        chk("r1_hold_cnt",      32'(m_if.cycle_cnt), 32'd5);

        // Restart from DONE with start_pc=0x100
        m_if.req = 1'b1;
        m_if.start_pc = 10'h100;
        tick();
        m_if.req = 1'b0;
        chk("r2_done_falls",    32'(m_if.done),      32'd0);
        chk("r2_pc_load",       32'(m_if.pc_load),   32'd1);
        chk("r2_pc_init",       32'(m_if.pc_init),   32'h100);
        chk("r2_cnt_cleared",   32'(m_if.cycle_cnt), 32'd0);
        tick_n(2);
        chk("r2_run_en",        32'(m_if.run_en),    32'd1);
        tick_n(2);
        m_if.halt = 1'b1;
        tick();
        m_if.halt = 1'b0;
        chk("r2_done",          32'(m_if.done),      32'd1);
        chk("r2_cnt",           32'(m_if.cycle_cnt), 32'd3);

        // abort and halt on the same RUN edge: abort wins
        m_if.req = 1'b1;
        tick();
        m_if.req = 1'b0;
        tick_n(4);
        chk("ab_cnt_before",    32'(m_if.cycle_cnt), 32'd2);
        m_if.abort = 1'b1;
        m_if.halt  = 1'b1;
        tick();
        m_if.abort = 1'b0;
        chk("ab_done",          32'(m_if.done),      32'd0);
        chk("ab_run_en",        32'(m_if.run_en),    32'd0);
        chk("ab_pc_load",       32'(m_if.pc_load),   32'd0);
        chk("ab_cnt_kept",      32'(m_if.cycle_cnt), 32'd3);
        chk("ab_timeout",       32'(m_if.timeout),   32'd0);
        // halt while IDLE is ignored
        tick();
        m_if.halt = 1'b0;
        chk("idle_halt_done",   32'(m_if.done),      32'd0);
        chk("idle_halt_cnt",    32'(m_if.cycle_cnt), 32'd3);

        // abort during INIT
        m_if.req = 1'b1;
        m_if.start_pc = 10'h055;
        tick();
        m_if.req = 1'b0;
        m_if.abort = 1'b1;
        tick();
        m_if.abort = 1'b0;
        chk("abi_pc_load",      32'(m_if.pc_load),   32'd0);
        chk("abi_cnt",          32'(m_if.cycle_cnt), 32'd0);
        tick();
        chk("abi_stays_idle",   32'(m_if.run_en),    32'd0);

        // Asynchronous reset mid-run with cycle_cnt=3
        m_if.req = 1'b1;
        tick();
        m_if.req = 1'b0;
        tick_n(5);
        chk("mr_cnt3",          32'(m_if.cycle_cnt), 32'd3);
        chk("mr_run_en",        32'(m_if.run_en),    32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("mr_run_en_async",  32'(m_if.run_en),    32'd0);
        chk("mr_cnt_async",     32'(m_if.cycle_cnt), 32'd0);
        chk("mr_done_async",    32'(m_if.done),      32'd0);
        chk("mr_pc_init_async", 32'(m_if.pc_init),   32'd0);
        #1;
        reset = 1'b0;
        tick();
        chk("mr_idle_run_en",   32'(m_if.run_en),    32'd0);
        chk("mr_idle_pc_load",  32'(m_if.pc_load),   32'd0);

        // req held high: back-to-back runs without an idle gap
        m_if.req = 1'b1;
        m_if.start_pc = 10'h3ff;
        tick_n(3);
        chk("bb_run_en",        32'(m_if.run_en),    32'd1);
        m_if.halt = 1'b1;
        tick();
        m_if.halt = 1'b0;
        chk("bb_done",          32'(m_if.done),      32'd1);
        chk("bb_cnt",           32'(m_if.cycle_cnt), 32'd1);
        tick();
        chk("bb_done_falls",    32'(m_if.done),      32'd0);
        chk("bb_pc_load",       32'(m_if.pc_load),   32'd1);
        chk("bb_pc_init",       32'(m_if.pc_init),   32'h3ff);
        m_if.req = 1'b0;
        tick_n(2);
        m_if.abort = 1'b1;
        tick();
        m_if.abort = 1'b0;
        chk("bb_abort_idle",    32'(m_if.run_en),    32'd0);

        // 4-bit counter saturates at 0xF; halt on the 20th RUN cycle
        s_if.req = 1'b1;
        s_if.start_pc = 10'h003;
        tick();
        s_if.req = 1'b0;
        tick_n(2);
        chk("sat_run_en",       32'(s_if.run_en),    32'd1);
        tick_n(19);
        chk("sat_cnt19",        32'(s_if.cycle_cnt), 32'hf);
        s_if.halt = 1'b1;
        tick();
        s_if.halt = 1'b0;
        chk("sat_done",         32'(s_if.done),      32'd1);
        chk("sat_cnt",          32'(s_if.cycle_cnt), 32'hf);

`ifdef RUN_WATCHDOG_EN
        // Watchdog expiry after 8 RUN cycles
        w_if.req = 1'b1;
        tick();
        w_if.req = 1'b0;
        tick_n(2);
        tick_n(7);
        chk("wd_cnt7_running",  32'(w_if.run_en),    32'd1);
        tick();
        chk("wd_done",          32'(w_if.done),      32'd1);
        chk("wd_timeout",       32'(w_if.timeout),   32'd1);
        chk("wd_cnt",           32'(w_if.cycle_cnt), 32'd8);
        // halt on the limit cycle wins
        w_if.req = 1'b1;
        tick();
        w_if.req = 1'b0;
        chk("wd2_timeout_clr",  32'(w_if.timeout),   32'd0);
        tick_n(2);
        tick_n(7);
        w_if.halt = 1'b1;
        tick();
        w_if.halt = 1'b0;
        chk("wd2_done",         32'(w_if.done),      32'd1);
        chk("wd2_timeout",      32'(w_if.timeout),   32'd0);
        chk("wd2_cnt",          32'(w_if.cycle_cnt), 32'd8);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
